// File: rtl/sd_pkg.sv
// Shared definitions for the SD-card RAM disk: FSM states, sector geometry and byte-offset type.
package sd_pkg;

  localparam int SECTOR_BYTES = 512;

  typedef logic [8:0] offset_t;

  localparam offset_t LAST_OFFSET = offset_t'(SECTOR_BYTES - 1);

  typedef enum logic [3:0] {
    IDLE,
    RD_REQ,
    RD_WAIT,
    RD_PUT,
    WR_ADDR,
    WR_CAPT,
    WR_REQ,
    WR_WAIT,
    DONE
  } sd_state_t;

endpackage

// File: rtl/sd_ramdisk.sv
// Serves SD sector reads/writes from a disk image held in SDRAM, one byte per memory access.
// Sectors beyond the mounted image read as FILL_BYTE and silently drop writes.
module sd_ramdisk
  import sd_pkg::*;
#(
  parameter logic [22:0] BASE_ADDR = 23'h020000,
  parameter logic [7:0]  FILL_BYTE = 8'h00
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        img_mounted,
  input  logic [31:0] img_size,
  input  logic [31:0] sd_lba,
  input  logic        sd_rd,
  input  logic        sd_wr,
  output logic        sd_ack,
  output logic [8:0]  sd_buff_addr,
  output logic [7:0]  sd_buff_dout,
  output logic        sd_buff_wr,
  input  logic [7:0]  sd_buff_din,
  output logic [22:0] mem_addr,
  output logic        mem_rd,
  output logic        mem_we,
  output logic [7:0]  mem_din,
  input  logic [7:0]  mem_dout,
  input  logic        mem_ready
);

  sd_state_t   r_state;
  sd_state_t   w_nextState;
  logic [13:0] r_lba;
  offset_t     r_offset;
  logic [22:0] r_imgSectors;
  logic        r_inRange;
  logic [7:0]  r_rdData;
  logic [7:0]  r_wrData;

  logic        w_lbaInRange;
  logic        w_lastByte;
  logic [22:0] w_memAddr;
  logic        w_unusedSizeLsbs;

  // Only whole sectors count toward the image; the trailing partial sector is out of range.
  assign w_unusedSizeLsbs = ^img_size[8:0];
  assign w_lbaInRange     = sd_lba < {9'd0, r_imgSectors};
  assign w_lastByte       = (r_offset == LAST_OFFSET);
  assign w_memAddr        = BASE_ADDR + {r_lba, r_offset};

  assign sd_buff_addr = r_offset;
  assign sd_buff_dout = r_rdData;
  assign mem_din      = r_wrData;
  assign mem_addr     = (r_state == IDLE) ? 23'd0 : w_memAddr;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    sd_ack      = 1'b0;
    sd_buff_wr  = 1'b0;
    mem_rd      = 1'b0;
    mem_we      = 1'b0;
    case (r_state)
      IDLE: begin
        if (sd_rd) begin
          w_nextState = RD_REQ;
        end else if (sd_wr) begin
          w_nextState = WR_ADDR;
        end
      end
      RD_REQ: begin
        sd_ack = 1'b1;
        if (r_inRange) begin
          mem_rd      = 1'b1;
          w_nextState = mem_ready ? RD_PUT : RD_WAIT;
        end else begin
          w_nextState = RD_PUT;
        end
      end
      RD_WAIT: begin
        sd_ack = 1'b1;
        mem_rd = 1'b1;
        if (mem_ready) begin
          w_nextState = RD_PUT;
        end
      end
      RD_PUT: begin
        sd_ack      = 1'b1;
        sd_buff_wr  = 1'b1;
        w_nextState = w_lastByte ? DONE : RD_REQ;
      end
      WR_ADDR: begin
        sd_ack      = 1'b1;
        w_nextState = WR_CAPT;
      end
      WR_CAPT: begin
        sd_ack      = 1'b1;
        w_nextState = WR_REQ;
      end
      WR_REQ: begin
        sd_ack = 1'b1;
        if (r_inRange) begin
          mem_we = 1'b1;
          if (mem_ready) begin
            w_nextState = w_lastByte ? DONE : WR_ADDR;
          end else begin
            w_nextState = WR_WAIT;
          end
        end else begin
          w_nextState = w_lastByte ? DONE : WR_ADDR;
        end
      end
      WR_WAIT: begin
        sd_ack = 1'b1;
        mem_we = 1'b1;
        if (mem_ready) begin
          w_nextState = w_lastByte ? DONE : WR_ADDR;
        end
      end
      DONE: begin
        // Wait for the request level to drop so one level yields exactly one transfer.
        if (!sd_rd && !sd_wr) begin
          w_nextState = IDLE;
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_lba        <= '0;
      r_offset     <= '0;
      r_imgSectors <= '0;
      r_inRange    <= 1'b0;
      r_rdData     <= '0;
      r_wrData     <= '0;
    end else begin
      if (img_mounted) begin
        r_imgSectors <= img_size[31:9];
      end
      case (r_state)
        IDLE: begin
          if (sd_rd || sd_wr) begin
            r_lba     <= sd_lba[13:0];
            r_inRange <= w_lbaInRange;
            r_offset  <= '0;
          end
        end
        RD_REQ: begin
          if (!r_inRange) begin
            r_rdData <= FILL_BYTE;
          end else if (mem_ready) begin
            r_rdData <= mem_dout;
          end
        end
        RD_WAIT: begin
          if (mem_ready) begin
            r_rdData <= mem_dout;
          end
        end
        RD_PUT: begin
          if (!w_lastByte) begin
            r_offset <= r_offset + 1'b1;
          end
        end
        WR_CAPT: begin
          r_wrData <= sd_buff_din;
        end
        WR_REQ: begin
          if (!w_lastByte && (!r_inRange || mem_ready)) begin
            r_offset <= r_offset + 1'b1;
          end
        end
        WR_WAIT: begin
          if (mem_ready && !w_lastByte) begin
            r_offset <= r_offset + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/sd_ramdisk.md
SD_RAMDISK -- requirements
Module: sd_ramdisk

Interface
REQ-001 Parameter BASE_ADDR, default 23'h020000: byte address in SDRAM where the disk image starts.
REQ-002 Parameter FILL_BYTE, default 8'h00: data returned for sectors outside the image.
REQ-003 clk_sys  in  1  system clock; one clock, all logic on its rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 img_mounted  in  1  one-cycle pulse; latches img_size.
REQ-006 img_size  in  32  image length in bytes.
REQ-007 sd_lba  in  32  sector number, valid while sd_rd/sd_wr is high.
REQ-008 sd_rd / sd_wr  in  1 each  level requests from the disk controller, held until sd_ack rises.
REQ-009 sd_ack  out  1  high for the whole transfer.
REQ-010 sd_buff_addr  out  9  byte offset within the sector.
REQ-011 sd_buff_dout  out  8  read data toward the controller buffer.
REQ-012 sd_buff_wr  out  1  one-cycle strobe; sd_buff_dout is valid at sd_buff_addr.
REQ-013 sd_buff_din  in  8  write data from the controller buffer, valid 1 cycle after sd_buff_addr changes.
REQ-014 mem_addr  out  23, mem_rd  out  1, mem_we  out  1, mem_din  out  8: SDRAM byte port.
REQ-015 mem_dout  in  8, mem_ready  in  1: read data and completion, one-cycle pulse per access.

Function
REQ-016 FSM states: IDLE, RD_REQ, RD_WAIT, RD_PUT, WR_ADDR, WR_CAPT, WR_REQ, WR_WAIT, DONE.
REQ-017 In IDLE with sd_rd=1, the block latches sd_lba, asserts sd_ack next cycle, clears the offset and enters RD_REQ; sd_rd takes priority when sd_rd and sd_wr are both high.
REQ-018 In IDLE with sd_wr=1 and sd_rd=0, the block latches sd_lba, asserts sd_ack, clears the offset and enters WR_ADDR.
REQ-019 mem_addr = BASE_ADDR + {lba, offset[8:0]}, truncated to 23 bits, and wraps silently.
REQ-020 A sector is in range when the image is mounted and lba < img_size[31:9]; partial trailing sectors are out of range.
REQ-021 RD_REQ, in range: mem_rd is held high until mem_ready, then RD_PUT; out of range: mem_rd is not asserted, the data is FILL_BYTE and the FSM goes straight to RD_PUT.
REQ-022 RD_PUT drives sd_buff_wr high for exactly one cycle with the current offset on sd_buff_addr, then increments the offset; offset 511 goes to DONE, otherwise to RD_REQ.
REQ-023 WR_ADDR presents the offset on sd_buff_addr; WR_CAPT samples sd_buff_din one cycle later.
REQ-024 WR_REQ, in range: mem_we is held high with mem_din until mem_ready; out of range: the byte is discarded and no mem_we is issued.
REQ-025 After each write byte, offset 511 goes to DONE, otherwise the FSM increments the offset and returns to WR_ADDR.
REQ-026 DONE deasserts sd_ack and waits until sd_rd=sd_wr=0 before IDLE, so one request level yields exactly one transfer.
REQ-027 mem_rd and mem_we are never high together, and neither is high in IDLE or DONE.
REQ-028 An img_mounted pulse mid-transfer updates the size for the next request only; the in-range decision is latched at acceptance.
REQ-029 Every transfer is exactly 512 bytes, in ascending offset order.

Reset
REQ-030 Reset forces IDLE; sd_ack, sd_buff_wr, mem_rd and mem_we go to 0; sd_buff_addr, sd_buff_dout, mem_addr, mem_din and the offset go to 0; the latched size clears, so the disk reads as unmounted.
REQ-031 Reset mid-transfer aborts immediately with no further memory strobes; a request still held after reset is served from offset 0.

Structure
REQ-032 FSM state enum, the SECTOR_BYTES=512 constant and the 9-bit offset type live in a shared package, sd_pkg.
REQ-033 Single flat module with no sub-modules; the address adder and range comparator are inline.

Verification
REQ-034 Mount img_size=1024, preload SDRAM, sd_rd with lba=1 -> 512 sd_buff_wr strobes, addresses 0..511, data = SDRAM[BASE+512..BASE+1023], then sd_ack falls.
REQ-035 sd_rd with lba=2 on the 1024-byte image -> 512 strobes of 8'h00 and zero mem_rd pulses.
REQ-036 sd_wr with lba=0 and buffer pattern addr^8'h5A -> SDRAM[BASE+n]=n^8'h5A for all n; mem_we count is 512.
REQ-037 sd_rd and sd_wr raised in the same cycle -> a read is performed and no mem_we is seen; with sd_rd held through DONE, no second transfer starts.
REQ-038 Assert reset at byte 100 of a read with random mem_ready delays (0-7 cycles) -> all outputs are 0 within the reset cycle; after release, a held sd_rd restarts at sd_buff_addr=0.
